// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, one transaction at a time.
// Optional ACCESS watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int address_width  = 32,
  parameter int data_width     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_read,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*address_width-1:0]  req_addr,
  input  logic [NUM_REQ*data_width-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [data_width-1:0]             req_rdata,
  output logic                              req_error,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              busy,
  output logic                              ram_en_read,
  output logic                              ram_en_write,
  output logic [address_width-1:0]          ram_addr,
  output logic [data_width-1:0]             ram_wdata,
  input  logic [data_width-1:0]             ram_rdata,
  input  logic                              ram_done
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic                    busy_q, busy_d;
  logic [NUM_REQ-1:0]      req_done_q, req_done_d;
  logic [data_width-1:0]   req_rdata_q, req_rdata_d;
  logic                    en_rd_q, en_rd_d;
  logic                    en_wr_q, en_wr_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]   wdata_q, wdata_d;
`ifdef ARB_TIMEOUT_EN
  logic [15:0]             cnt_q, cnt_d;
  logic                    req_error_q, req_error_d;
`endif

  logic [address_width-1:0] addr_arr  [NUM_REQ];
  logic [data_width-1:0]    wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]       active;
  logic                     found;
  logic [GW-1:0]            win;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*address_width +: address_width];
    assign wdata_arr[i] = req_wdata[i*data_width +: data_width];
  end

  assign active = req_read | req_write;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    return GW'((int'(base) + k) % NUM_REQ);
  endfunction

  // Search begins one past the last winner so the previous grantee has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && active[rr_idx(rr_ptr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    busy_d      = busy_q;
    req_done_d  = req_done_q;
    req_rdata_d = req_rdata_q;
    en_rd_d     = en_rd_q;
    en_wr_d     = en_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    req_error_d = req_error_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = win;
          rr_ptr_d   = win;
          busy_d     = 1'b1;
          addr_d     = addr_arr[win];
          wdata_d    = wdata_arr[win];
          en_wr_d    = req_write[win];
          en_rd_d    = ~req_write[win];
          state_d    = ACCESS;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ACCESS: begin
        if (ram_done) begin
          en_rd_d = 1'b0;
          en_wr_d = 1'b0;
          if (en_rd_q) req_rdata_d = ram_rdata;
          req_done_d             = '0;
          req_done_d[grant_id_q] = 1'b1;
          state_d                = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          en_rd_d                = 1'b0;
          en_wr_d                = 1'b0;
          req_done_d             = '0;
          req_done_d[grant_id_q] = 1'b1;
          req_error_d            = 1'b1;
          state_d                = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        req_done_d = '0;
        busy_d     = 1'b0;
        state_d    = IDLE;
`ifdef ARB_TIMEOUT_EN
        req_error_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= GW'(NUM_REQ - 1);
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      req_done_q  <= '0;
      req_rdata_q <= '0;
      en_rd_q     <= 1'b0;
      en_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      req_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      req_done_q  <= req_done_d;
      req_rdata_q <= req_rdata_d;
      en_rd_q     <= en_rd_d;
      en_wr_q     <= en_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      req_error_q <= req_error_d;
`endif
    end
  end

  assign req_done     = req_done_q;
  assign req_rdata    = req_rdata_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign ram_en_read  = en_rd_q;
  assign ram_en_write = en_wr_q;
  assign ram_addr     = addr_q;
  assign ram_wdata    = wdata_q;
`ifdef ARB_TIMEOUT_EN
  assign req_error    = req_error_q;
`else
  assign req_error    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, directed corner sequences, and
// randomized transactions against a transaction-level round-robin model.
module tb_ram_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_read, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  req_done;
  logic [DW-1:0] req_rdata;
  logic          req_error;
  logic          grant_id;
  logic          busy, ram_en_read, ram_en_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.NUM_REQ(N), .address_width(AW), .data_width(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_error(req_error),
    .grant_id(grant_id), .busy(busy),
    .ram_en_read(ram_en_read), .ram_en_write(ram_en_write),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_done(ram_done)
  );

  typedef struct {
    logic [1:0]  rd, wr;
    logic        dn;
    logic [31:0] rdat;
    logic        er, ew, b;
    logic [1:0]  d;
    logic        g;
    logic [31:0] rdata, addr, wdata;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_read  = '0;
    req_write = '0;
    ram_done  = 1'b0;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
  endtask

  task automatic complete(input int lat, input logic [31:0] d);
    repeat (lat) begin
      ram_done = 1'b0;
      step();
    end
    ram_done  = 1'b1;
    ram_rdata = d;
    step();
    ram_done  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a_s [N];
    logic [31:0] w_s [N];
    logic [1:0]  rd, wr, act;
    logic [31:0] mrdata, r;
    int          last, w, lat;
    logic        iswr;

    req_addr  = {32'h0000_0080, 32'h0000_0040};
    req_wdata = {32'h1111_2222, 32'h3333_4444};
    ram_rdata = '0;
    do_reset();
    reset = 1'b1;
    step();
    chk("rst en_r", 32'(ram_en_read), 0);
    chk("rst en_w", 32'(ram_en_write), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(req_done), 0);
    chk("rst gid", 32'(grant_id), 0);
    chk("rst rdata", req_rdata, 0);
    chk("rst addr", ram_addr, 0);
    chk("rst err", 32'(req_error), 0);
    reset = 1'b0;

    // rd, wr, dn, rdat, | en_r, en_w, busy, done, gid, rdata, addr, wdata
    tbl[0] = '{2'b01, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0,        32'h40, 32'h3333_4444};
    tbl[1] = '{2'b01, 2'b00, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0,        32'h40, 32'h3333_4444};
    tbl[2] = '{2'b01, 2'b00, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'hDEADBEEF, 32'h40, 32'h3333_4444};
    tbl[3] = '{2'b01, 2'b00, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF, 32'h40, 32'h3333_4444};
    tbl[4] = '{2'b00, 2'b00, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF, 32'h40, 32'h3333_4444};
    tbl[5] = '{2'b10, 2'b10, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 32'hDEADBEEF, 32'h80, 32'h1111_2222};
    tbl[6] = '{2'b10, 2'b10, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 32'hDEADBEEF, 32'h80, 32'h1111_2222};
    tbl[7] = '{2'b10, 2'b10, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF, 32'h80, 32'h1111_2222};
    tbl[8] = '{2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF, 32'h80, 32'h1111_2222};

    for (int i = 0; i < 9; i++) begin
      req_read  = tbl[i].rd;
      req_write = tbl[i].wr;
      ram_done  = tbl[i].dn;
      ram_rdata = tbl[i].rdat;
      step();
      chk($sformatf("t%0d en_r", i), 32'(ram_en_read), 32'(tbl[i].er));
      chk($sformatf("t%0d en_w", i), 32'(ram_en_write), 32'(tbl[i].ew));
      chk($sformatf("t%0d busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("t%0d done", i), 32'(req_done), 32'(tbl[i].d));
      chk($sformatf("t%0d gid", i), 32'(grant_id), 32'(tbl[i].g));
      chk($sformatf("t%0d rdata", i), req_rdata, tbl[i].rdata);
      chk($sformatf("t%0d addr", i), ram_addr, tbl[i].addr);
      chk($sformatf("t%0d wdata", i), ram_wdata, tbl[i].wdata);
      chk($sformatf("t%0d err", i), 32'(req_error), 0);
    end
    ram_done = 1'b0;

    // Simultaneous read(0) / write(1) from reset: 0 first, then 1.
    do_reset();
    req_read  = 2'b01;
    req_write = 2'b10;
    step();
    chk("pair g0", 32'(grant_id), 0);
    chk("pair en_r0", 32'(ram_en_read), 1);
    chk("pair en_w0", 32'(ram_en_write), 0);
    complete(1, 32'h0000_A5A5);
    chk("pair done0", 32'(req_done), 32'h1);
    chk("pair rdata0", req_rdata, 32'h0000_A5A5);
    step();
    chk("pair idle busy", 32'(busy), 0);
    step();
    chk("pair g1", 32'(grant_id), 1);
    chk("pair en_w1", 32'(ram_en_write), 1);
    chk("pair en_r1", 32'(ram_en_read), 0);
    chk("pair wdata1", ram_wdata, 32'h1111_2222);
    complete(0, 32'h5555_0000);
    chk("pair done1", 32'(req_done), 32'h2);
    chk("pair rdata1", req_rdata, 32'h0000_A5A5);
    step();

    // Continuous requests from both: strict alternation.
    do_reset();
    req_read  = 2'b11;
    req_write = 2'b00;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("alt%0d gid", i), 32'(grant_id), 32'(i % 2));
      chk($sformatf("alt%0d en_r", i), 32'(ram_en_read), 1);
      complete(i % 3, 32'(i));
      chk($sformatf("alt%0d done", i), 32'(req_done), 32'(1 << (i % 2)));
      step();
    end

    // Reset in the middle of ACCESS abandons the transaction.
    do_reset();
    req_read = 2'b01;
    step();
    step();
    chk("mid en_r", 32'(ram_en_read), 1);
    reset    = 1'b1;
    ram_done = 1'b1;
    step();
    chk("mid rst en_r", 32'(ram_en_read), 0);
    chk("mid rst en_w", 32'(ram_en_write), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst done", 32'(req_done), 0);
    reset    = 1'b0;
    ram_done = 1'b0;
    req_read = 2'b10;
    step();
    chk("mid after done", 32'(req_done), 0);
    chk("mid after gid", 32'(grant_id), 1);
    chk("mid after en_r", 32'(ram_en_read), 1);
    req_read = 2'b00;
    complete(0, 32'h0BAD_F00D);
    chk("mid after done1", 32'(req_done), 32'h2);
    chk("mid after rdata", req_rdata, 32'h0BAD_F00D);
    step();

`ifdef ARB_TIMEOUT_EN
    do_reset();
    req_read = 2'b01;
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("to cyc%0d en_r", c), 32'(ram_en_read), 1);
    end
    step();
    chk("to en_r", 32'(ram_en_read), 0);
    chk("to done", 32'(req_done), 32'h1);
    chk("to err", 32'(req_error), 1);
    chk("to rdata", req_rdata, 0);
    step();
    chk("to resp err", 32'(req_error), 0);
    chk("to resp busy", 32'(busy), 0);
    step();
    chk("to2 gid", 32'(grant_id), 0);
    for (int c = 0; c < 3; c++) step();
    chk("to2 en_r", 32'(ram_en_read), 1);
    ram_done  = 1'b1;
    ram_rdata = 32'hCAFE_0001;
    step();
    ram_done = 1'b0;
    req_read = 2'b00;
    chk("to2 done", 32'(req_done), 32'h1);
    chk("to2 err", 32'(req_error), 0);
    chk("to2 rdata", req_rdata, 32'hCAFE_0001);
    step();
`endif

    // Randomized transactions against a transaction-level model.
    do_reset();
    last   = N - 1;
    mrdata = '0;
    for (int it = 0; it < 40; it++) begin
      rd = 2'($urandom);
      wr = 2'($urandom);
      for (int j = 0; j < N; j++) begin
        a_s[j] = $urandom;
        w_s[j] = $urandom;
      end
      req_addr  = {a_s[1], a_s[0]};
      req_wdata = {w_s[1], w_s[0]};
      req_read  = rd;
      req_write = wr;
      ram_done  = 1'($urandom);
      act = rd | wr;
      step();
      if (act == 2'b00) begin
        chk("rnd idle busy", 32'(busy), 0);
        chk("rnd idle en", 32'({ram_en_read, ram_en_write}), 0);
        continue;
      end
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && act[(last + k) % N]) w = (last + k) % N;
      last = w;
      iswr = wr[w];
      chk($sformatf("rnd%0d gid", it), 32'(grant_id), 32'(w));
      chk($sformatf("rnd%0d en_w", it), 32'(ram_en_write), 32'(iswr));
      chk($sformatf("rnd%0d en_r", it), 32'(ram_en_read), 32'(!iswr));
      chk($sformatf("rnd%0d addr", it), ram_addr, a_s[w]);
      chk($sformatf("rnd%0d wdata", it), ram_wdata, w_s[w]);
      chk($sformatf("rnd%0d busy", it), 32'(busy), 1);
      lat = $urandom_range(0, 3);
      for (int c = 0; c < lat; c++) begin
        ram_done  = 1'b0;
        req_read  = 2'($urandom);
        req_write = 2'($urandom);
        ram_rdata = $urandom;
        step();
        chk($sformatf("rnd%0d hold en", it), 32'({ram_en_read, ram_en_write}), 32'({!iswr, iswr}));
      end
      r = $urandom;
      ram_done  = 1'b1;
      ram_rdata = r;
      step();
      if (!iswr) mrdata = r;
      chk($sformatf("rnd%0d done", it), 32'(req_done), 32'(1 << w));
      chk($sformatf("rnd%0d rdata", it), req_rdata, mrdata);
      chk($sformatf("rnd%0d en off", it), 32'({ram_en_read, ram_en_write}), 0);
      ram_done  = 1'($urandom);
      req_read  = 2'($urandom);
      req_write = 2'($urandom);
      step();
      chk($sformatf("rnd%0d resp done", it), 32'(req_done), 0);
      chk($sformatf("rnd%0d resp busy", it), 32'(busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one RAM port between NUM_REQ cache controllers, e.g. the instruction-cache and data-cache controllers.
- Uses round-robin arbitration and a level-request / done-pulse handshake on each side.
- Sits between the cache controllers' RAM enable/done interface and the single RAM model.
- Serves one transaction at a time. The address and write data are latched at grant.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- address_width, 32, RAM address width.
- data_width, 32, RAM data width.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read request (level).
- req_write  in  NUM_REQ  per-requester write request (level).
- req_addr  in  NUM_REQ*address_width  flattened addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*data_width  flattened write data; requester i uses slice i.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  data_width  read data, valid while req_done is high.
- req_error  out  1  high with req_done when the transaction was aborted by timeout.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high while a transaction is in progress.
- ram_en_read  out  1  RAM read enable (level).
- ram_en_write  out  1  RAM write enable (level).
- ram_addr  out  address_width  latched address.
- ram_wdata  out  data_width  latched write data.
- ram_rdata  in  data_width  RAM read data, valid when ram_done is high.
- ram_done  in  1  RAM completion.

Behaviour:
- All outputs are registered.
- Reset (also mid-transaction): state IDLE, every output 0, rr_ptr = NUM_REQ-1 so requester 0 has top priority. Any in-flight RAM access is abandoned, with both enables low the cycle after reset.
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - Requester i is active if req_read[i] or req_write[i] is high.
  - Search starts at rr_ptr+1 modulo NUM_REQ; the first active index wins.
  - On a win at edge E: latch addr and wdata, set grant_id and rr_ptr to the winner, busy=1, and raise the enable. The enable is ram_en_write if req_write is set, otherwise ram_en_read; write wins if both are high. The state moves to ACCESS.
  - RAM enables are therefore high the cycle after the request is first seen.
- ACCESS:
  - Enables are held until ram_done is sampled high.
  - On that edge: enables go to 0, req_rdata is latched from ram_rdata (reads only; writes leave it unchanged), req_done[grant_id]=1, and the state moves to RESP.
  - Request lines are not resampled during ACCESS. Dropping a request does not abort it.
- RESP:
  - req_done is high for exactly one cycle. At the next edge it clears, busy=0, and the state returns to IDLE.
  - Requesters must clear their request at the edge where they sample req_done=1. A request still high in the following IDLE cycle is a new request.
- Minimum turnaround: 3 cycles per transaction (IDLE, ACCESS with ram_done=1, RESP).
- Fairness: each requester is served at most once per NUM_REQ consecutive grants while others are pending.
- ram_done while in IDLE or RESP is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8..16-bit counter clears on entering ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES without ram_done, enables drop, req_done[grant_id]=1 with req_error=1, req_rdata is unchanged, and the state moves to RESP.
  - ram_done arriving on the same cycle as the timeout wins, so the transaction completes normally.
- Without the macro: no counter is built, req_error is tied to 0, and ACCESS waits indefinitely.

Test Plan:
- req_read[0]=1, addr 0x40, RAM returns 0xDEADBEEF with ram_done 2 cycles after the enable -> ram_en_read=1 with ram_addr=0x40 one cycle after the request; req_done[0] pulses for one cycle with req_rdata=0xDEADBEEF; busy falls the cycle after.
- req_read[0] and req_write[1] both asserted from reset -> requester 0 is served first. Requester 1 is then served with ram_en_write=1 and ram_wdata equal to its slice. grant_id sequence is 0,1.
- Both requesters re-request continuously for 6 transactions -> grant_id alternates 0,1,0,1,0,1 and neither is starved.
- req_read[1] and req_write[1] both high -> only ram_en_write asserts; req_rdata is unchanged after completion.
- reset asserted for one cycle mid-ACCESS -> the next cycle shows ram_en_read=0, ram_en_write=0, busy=0, req_done=0, and no req_done pulse for the aborted transaction. A fresh request from requester 1 is then granted normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ram_done held low -> the enable drops after 4 ACCESS cycles and req_done[g]=1 with req_error=1. Repeat with ram_done=1 on cycle 4 -> normal completion with req_error=0.
